// File: rtl/stream_vadd_nch.sv
// N-input elementwise stream reducer (add/max/min) with eot-framed transfers
// and ap_start/ap_done control. One registered output slot feeds c_din.
module stream_vadd_nch #(
    parameter int NCH        = 3,
    parameter int W          = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [1:0]         mode,
    input  logic [NCH*W-1:0]   in_s_dout,
    input  logic [NCH-1:0]     in_s_dout_eot,
    input  logic [NCH-1:0]     in_s_empty_n,
    output logic [NCH-1:0]     in_s_read,
    output logic [W-1:0]       c_din,
    output logic               c_din_eot,
    input  logic               c_full_n,
    output logic               c_write,
    output logic               err_mismatch,
    output logic [31:0]        elem_count
);

    localparam int LVLS   = $clog2(NCH);
    localparam int LEAVES = 1 << LVLS;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_CLOSE, S_DONE} state_t;

    function automatic logic isGreater(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED_CMP) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Balanced max/min tree; unused leaves repeat operand 0, which cannot change the result.
    function automatic logic [W-1:0] reduceSel(input logic [NCH*W-1:0] v, input logic wantMax);
        logic [W-1:0] t [2*LEAVES-1];
        for (int i = 0; i < LEAVES; i++) begin
            int idx;
            idx = (i < NCH) ? i : 0;
            t[LEAVES-1+i] = v[idx*W +: W];
        end
        for (int n = LEAVES - 2; n >= 0; n--)
            t[n] = (isGreater(t[2*n+1], t[2*n+2]) == wantMax) ? t[2*n+1] : t[2*n+2];
        return t[0];
    endfunction

    function automatic logic [W-1:0] reduceAdd(input logic [NCH*W-1:0] v);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < NCH; k++)
            s = s + v[k*W +: W];
        return s;
    endfunction

    state_t         r_state;
    logic [1:0]     r_mode;
    logic           r_outVld;
    logic [W-1:0]   r_din;
    logic           r_dinEot;
    logic           r_err;
    logic [31:0]    r_count;

    logic           w_allValid;
    logic           w_allEot;
    logic           w_anyEot;
    logic           w_slotFree;
    logic           w_fire;
    logic           w_close;
    logic           w_mismatch;
    logic [W-1:0]   w_result;

    assign c_write    = r_outVld & c_full_n;
    assign w_slotFree = !r_outVld || c_write;
    assign w_allValid = &in_s_empty_n;
    assign w_allEot   = &in_s_dout_eot;
    assign w_anyEot   = |in_s_dout_eot;
    assign w_fire     = (r_state == S_RUN) && w_allValid && !w_anyEot && w_slotFree;
    assign w_close    = ((r_state == S_RUN) || (r_state == S_FLUSH))
                        && w_allValid && w_allEot && w_slotFree;
    assign w_mismatch = (r_state == S_RUN) && w_allValid && w_anyEot && !w_allEot;

    // In FLUSH, non-eot heads are drained while eot heads wait for the others.
    always_comb begin
        in_s_read = '0;
        if (w_fire || w_close)
            in_s_read = '1;
        else if (r_state == S_FLUSH)
            in_s_read = in_s_empty_n & ~in_s_dout_eot;
    end

    always_comb begin
        w_result = '0;
        case (r_mode)
            2'd1:    w_result = reduceSel(in_s_dout, 1'b1);
            2'd2:    w_result = reduceSel(in_s_dout, 1'b0);
            default: w_result = reduceAdd(in_s_dout);
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_outVld <= 1'b0;
            r_din    <= '0;
            r_dinEot <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            if (c_write)
                r_outVld <= 1'b0;
            if (w_fire) begin
                r_din    <= w_result;
                r_dinEot <= 1'b0;
                r_outVld <= 1'b1;
                if (r_count != 32'hFFFF_FFFF)
                    r_count <= r_count + 32'd1;
            end
            if (w_close) begin
                r_din    <= '0;
                r_dinEot <= 1'b1;
                r_outVld <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_mode  <= mode;
                        r_err   <= 1'b0;
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_close) begin
                        r_state <= S_CLOSE;
                    end else if (w_mismatch) begin
                        r_err   <= 1'b1;
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: if (w_close) r_state <= S_CLOSE;
                S_CLOSE: if (c_write) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ap_idle      = (r_state == S_IDLE);
    assign ap_done      = (r_state == S_DONE);
    assign ap_ready     = (r_state == S_DONE);
    assign c_din        = r_din;
    assign c_din_eot    = r_dinEot;
    assign err_mismatch = r_err;
    assign elem_count   = r_count;

endmodule

// File: tb/tb_stream_vadd_nch.sv
// Self-checking bench: per-channel stream FIFOs feed two DUT copies (signed and
// unsigned compare); a scoreboard queue holds the expected output tokens.
module tb_stream_vadd_nch;

    localparam int NCH    = 3;
    localparam int W      = 32;
    localparam int MAXLEN = 6;
    localparam int NV     = 8;

    typedef struct packed {
        logic         eot;
        logic [W-1:0] data;
        logic [W-1:0] dataU;
    } tok_t;

    typedef struct packed {
        logic [1:0]                         mode;
        logic                               stall;
        logic                               b2b;
        logic [NCH-1:0][3:0]                len;
        logic [NCH-1:0][MAXLEN-1:0][W-1:0]  d;
    } vec_t;

    logic               ap_clk = 1'b0;
    logic               ap_rst, ap_start;
    logic               ap_done, ap_idle, ap_ready;
    logic [1:0]         mode;
    logic [NCH*W-1:0]   in_s_dout;
    logic [NCH-1:0]     in_s_dout_eot, in_s_empty_n, in_s_read;
    logic [W-1:0]       c_din;
    logic               c_din_eot, c_full_n, c_write, err_mismatch;
    logic [31:0]        elem_count;

    logic               uDone, uIdle, uReady, uDinEot, uWrite, uErr;
    logic [NCH-1:0]     uRead;
    logic [W-1:0]       uDin;
    logic [31:0]        uCount;

    always #5 ap_clk = ~ap_clk;

    stream_vadd_nch #(.NCH(NCH), .W(W), .SIGNED_CMP(1'b1)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .mode(mode),
        .in_s_dout(in_s_dout), .in_s_dout_eot(in_s_dout_eot),
        .in_s_empty_n(in_s_empty_n), .in_s_read(in_s_read),
        .c_din(c_din), .c_din_eot(c_din_eot), .c_full_n(c_full_n), .c_write(c_write),
        .err_mismatch(err_mismatch), .elem_count(elem_count)
    );

    stream_vadd_nch #(.NCH(NCH), .W(W), .SIGNED_CMP(1'b0)) dutU (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(uDone), .ap_idle(uIdle), .ap_ready(uReady), .mode(mode),
        .in_s_dout(in_s_dout), .in_s_dout_eot(in_s_dout_eot),
        .in_s_empty_n(in_s_empty_n), .in_s_read(uRead),
        .c_din(uDin), .c_din_eot(uDinEot), .c_full_n(c_full_n), .c_write(uWrite),
        .err_mismatch(uErr), .elem_count(uCount)
    );

    tok_t        chQ[NCH][$];
    tok_t        expQ[$];
    vec_t        vecs[NV];
    int          checks = 0, errors = 0;
    int          doneCount, writeCount, firstWr, lastWr, cyc, protoErr;
    bit          tbHeld, prevStall, stallOn;
    logic [W-1:0] prevDin;
    logic        startNext, rstNext;
    logic [1:0]  modeNext;
    logic [3:0]  stallPat = 4'b1001;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Linear reference reduction, deliberately structured differently from the RTL tree.
    function automatic logic [W-1:0] modelOp(input logic [1:0] m, input logic [NCH-1:0][W-1:0] ops, input bit sgn);
        logic [W-1:0] acc;
        acc = ops[0];
        for (int k = 1; k < NCH; k++) begin
            case (m)
                2'd1: if (sgn ? ($signed(ops[k]) > $signed(acc)) : (ops[k] > acc)) acc = ops[k];
                2'd2: if (sgn ? ($signed(ops[k]) < $signed(acc)) : (ops[k] < acc)) acc = ops[k];
                default: acc = acc + ops[k];
            endcase
        end
        return acc;
    endfunction

    task automatic applyStimulus();
        @(negedge ap_clk);
        ap_rst    = rstNext;
        ap_start  = startNext;
        mode      = modeNext;
        startNext = 1'b0;
        rstNext   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (chQ[k].size() > 0) begin
                in_s_empty_n[k]        = 1'b1;
                in_s_dout[k*W +: W]    = chQ[k][0].data;
                in_s_dout_eot[k]       = chQ[k][0].eot;
            end else begin
                in_s_empty_n[k]        = 1'b0;
                in_s_dout[k*W +: W]    = '0;
                in_s_dout_eot[k]       = 1'b0;
            end
        end
        c_full_n = stallOn ? stallPat[cyc % 4] : 1'b1;
    endtask

    // Sample mid-cycle, score any write, then model the FIFO pops taken at the next edge.
    task automatic stepCycle();
        tok_t e;
        applyStimulus();
        #2;
        if (ap_done !== ap_ready) protoErr++;
        if (c_write !== uWrite || in_s_read !== uRead) protoErr++;
        if ((in_s_read & ~in_s_empty_n) != '0) protoErr++;
        if (tbHeld && prevStall && c_din !== prevDin) protoErr++;
        if (tbHeld && !c_full_n && in_s_read != '0) protoErr++;
        if (ap_done) doneCount++;
        if (c_write) begin
            writeCount++;
            if (firstWr < 0) firstWr = cyc;
            lastWr = cyc;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL extra_write: actual c_din=%0h eot=%0b required no write", c_din, c_din_eot);
            end else begin
                e = expQ.pop_front();
                checkOutput("c_din", {32'd0, c_din}, {32'd0, e.data});
                checkOutput("c_din_eot", {63'd0, c_din_eot}, {63'd0, e.eot});
                checkOutput("c_din_unsigned", {32'd0, uDin}, {32'd0, e.dataU});
            end
        end
        for (int k = 0; k < NCH; k++)
            if (in_s_read[k] && chQ[k].size() > 0) e = chQ[k].pop_front();
        prevStall = tbHeld && !c_full_n;
        prevDin   = c_din;
        tbHeld    = (tbHeld && !c_write) || (&in_s_read);
        cyc++;
    endtask

    task automatic loadVector(input int v, output int minLen, output bit expErr);
        tok_t t;
        logic [NCH-1:0][W-1:0] ops;
        minLen = MAXLEN;
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < int'(vecs[v].len[k]); i++) begin
                t = '{eot: 1'b0, data: vecs[v].d[k][i], dataU: '0};
                chQ[k].push_back(t);
            end
            t = '{eot: 1'b1, data: '0, dataU: '0};
            chQ[k].push_back(t);
            if (int'(vecs[v].len[k]) < minLen) minLen = int'(vecs[v].len[k]);
        end
        expErr = 1'b0;
        for (int k = 0; k < NCH; k++)
            if (int'(vecs[v].len[k]) != minLen) expErr = 1'b1;
        for (int i = 0; i < minLen; i++) begin
            for (int k = 0; k < NCH; k++) ops[k] = vecs[v].d[k][i];
            t = '{eot: 1'b0, data: modelOp(vecs[v].mode, ops, 1'b1), dataU: modelOp(vecs[v].mode, ops, 1'b0)};
            expQ.push_back(t);
        end
        t = '{eot: 1'b1, data: '0, dataU: '0};
        expQ.push_back(t);
    endtask

    task automatic runTransfer(input int v, input string tag);
        int minLen, left;
        bit expErr;
        loadVector(v, minLen, expErr);
        doneCount = 0; writeCount = 0; firstWr = -1; lastWr = -1; protoErr = 0; cyc = 0;
        stallOn   = vecs[v].stall;
        startNext = 1'b1;
        modeNext  = vecs[v].mode;
        for (int n = 0; n < 300 && doneCount == 0; n++) stepCycle();
        if (doneCount == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s/timeout: actual no ap_done required ap_done within 300 cycles", tag);
        end
        stepCycle();
        stepCycle();
        left = 0;
        for (int k = 0; k < NCH; k++) left += chQ[k].size();
        checkOutput({tag, "/done_pulses"}, 64'(doneCount), 64'd1);
        checkOutput({tag, "/err_mismatch"}, {63'd0, err_mismatch}, {63'd0, expErr});
        checkOutput({tag, "/elem_count"}, {32'd0, elem_count}, 64'(minLen));
        checkOutput({tag, "/pending_expected"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, "/unconsumed_inputs"}, 64'(left), 64'd0);
        checkOutput({tag, "/protocol_errors"}, 64'(protoErr), 64'd0);
        checkOutput({tag, "/ap_idle"}, {63'd0, ap_idle}, 64'd1);
        if (vecs[v].b2b)
            checkOutput({tag, "/back_to_back"}, 64'(lastWr - firstWr + 1), 64'(writeCount));
        expQ.delete();
        for (int k = 0; k < NCH; k++) chQ[k].delete();
    endtask

    initial begin
        for (int v = 0; v < NV; v++) vecs[v] = '0;
        for (int i = 0; i < 5; i++) begin
            vecs[0].d[0][i] = 32'(i);
            vecs[0].d[1][i] = 32'(i + 1);
            vecs[0].d[2][i] = 32'(i + 10);
        end
        vecs[0].len = {4'd5, 4'd5, 4'd5};
        vecs[0].b2b = 1'b1;
        vecs[1] = vecs[0];
        vecs[1].stall = 1'b1;
        vecs[1].b2b   = 1'b0;
        vecs[2].mode = 2'd1; vecs[2].b2b = 1'b1; vecs[2].len = {4'd2, 4'd2, 4'd2};
        vecs[2].d[0][0] = 32'hFFFF_FFFD; vecs[2].d[1][0] = 32'd7;           vecs[2].d[2][0] = 32'd2;
        vecs[2].d[0][1] = 32'd5;         vecs[2].d[1][1] = 32'hFFFF_FFF8;   vecs[2].d[2][1] = 32'd5;
        vecs[3].mode = 2'd2; vecs[3].b2b = 1'b1; vecs[3].len = {4'd2, 4'd2, 4'd2};
        vecs[3].d[0][0] = 32'hFFFF_FFFF; vecs[3].d[1][0] = 32'd1;           vecs[3].d[2][0] = 32'd2;
        vecs[3].d[0][1] = 32'd7;         vecs[3].d[1][1] = 32'hFFFF_FFFE;   vecs[3].d[2][1] = 32'd3;
        vecs[4].len = {4'd4, 4'd2, 4'd4};
        for (int i = 0; i < 4; i++) begin
            vecs[4].d[0][i] = 32'(i + 1);
            vecs[4].d[2][i] = 32'((i + 1) * 100);
        end
        vecs[4].d[1][0] = 32'd10; vecs[4].d[1][1] = 32'd20;
        vecs[5].b2b = 1'b1;
        vecs[6].b2b = 1'b1; vecs[6].len = {4'd1, 4'd1, 4'd1};
        vecs[6].d[0][0] = 32'hFFFF_FFFF; vecs[6].d[1][0] = 32'd1; vecs[6].d[2][0] = 32'd1;
        vecs[7].mode = 2'd3; vecs[7].b2b = 1'b1; vecs[7].len = {4'd1, 4'd1, 4'd1};
        vecs[7].d[0][0] = 32'd5; vecs[7].d[1][0] = 32'd6; vecs[7].d[2][0] = 32'd7;

        ap_rst = 1'b1; ap_start = 1'b0; mode = '0; c_full_n = 1'b1;
        in_s_dout = '0; in_s_dout_eot = '0; in_s_empty_n = '0;
        startNext = 1'b0; modeNext = '0; stallOn = 1'b0; cyc = 0;
        tbHeld = 1'b0; prevStall = 1'b0; prevDin = '0;
        doneCount = 0; writeCount = 0; firstWr = -1; lastWr = -1; protoErr = 0;

        rstNext = 1'b1; stepCycle();
        rstNext = 1'b1; stepCycle();
        stepCycle();
        checkOutput("rst/ap_idle", {63'd0, ap_idle}, 64'd1);
        checkOutput("rst/ap_done", {63'd0, ap_done}, 64'd0);
        checkOutput("rst/ap_ready", {63'd0, ap_ready}, 64'd0);
        checkOutput("rst/c_write", {63'd0, c_write}, 64'd0);
        checkOutput("rst/c_din", {32'd0, c_din}, 64'd0);
        checkOutput("rst/c_din_eot", {63'd0, c_din_eot}, 64'd0);
        checkOutput("rst/err_mismatch", {63'd0, err_mismatch}, 64'd0);
        checkOutput("rst/elem_count", {32'd0, elem_count}, 64'd0);

        for (int v = 0; v < NV; v++) runTransfer(v, $sformatf("vec%0d", v));

        // Reset after two outputs must abort with no eot and no done pulse.
        begin
            int minLen;
            bit expErr;
            loadVector(0, minLen, expErr);
            doneCount = 0; writeCount = 0; stallOn = 1'b0; cyc = 0;
            startNext = 1'b1; modeNext = 2'd0;
            for (int n = 0; n < 50 && writeCount < 2; n++) stepCycle();
            checkOutput("midrst/writes_before", 64'(writeCount), 64'd2);
            rstNext = 1'b1;
            stepCycle();
            expQ.delete();
            for (int k = 0; k < NCH; k++) chQ[k].delete();
            tbHeld = 1'b0; prevStall = 1'b0; doneCount = 0;
            stepCycle();
            checkOutput("midrst/ap_idle", {63'd0, ap_idle}, 64'd1);
            checkOutput("midrst/c_write", {63'd0, c_write}, 64'd0);
            checkOutput("midrst/c_din_eot", {63'd0, c_din_eot}, 64'd0);
            checkOutput("midrst/elem_count", {32'd0, elem_count}, 64'd0);
            for (int n = 0; n < 4; n++) stepCycle();
            checkOutput("midrst/no_done", 64'(doneCount), 64'd0);
        end
        runTransfer(0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/stream_vadd_nch.md
Name: stream_vadd_nch

Overview:
- N-input, single-output elementwise reducer over HLS-style streams with end-of-transfer (eot) tokens; a parametrised RTL successor of the two-input VecAdd kernel.
- Each output token is add, max or min across one head token from every input stream.
- A transfer closes when all inputs present eot. The block then forwards one eot token and pulses ap_done.
- Sits between stream FIFOs in the stream-vadd app family and uses the ap_start/ap_done/ap_idle/ap_ready control convention.

Parameters:
- NCH, 3, number of input streams (2..16).
- W, 32, data width in bits.
- SIGNED_CMP, 1, 1 = max/min compare signed; 0 = unsigned.

Ports:
- ap_clk  in  1  clock; all logic on its rising edge.
- ap_rst  in  1  synchronous active-high reset.
- ap_start  in  1  level start request.
- ap_done  out  1  one-cycle pulse after eot token is written.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done.
- mode  in  2  0 add, 1 max, 2 min, 3 reserved (behaves as add); sampled at start.
- in_s_dout  in  NCH*W  head data; channel k at bits [k*W +: W].
- in_s_dout_eot  in  NCH  head eot flag per channel.
- in_s_empty_n  in  NCH  head valid per channel.
- in_s_read  out  NCH  pop per channel. A pop occurs when read is high; read is only asserted when empty_n is high.
- c_din  out  W  output data.
- c_din_eot  out  1  output eot flag.
- c_full_n  in  1  downstream has space.
- c_write  out  1  push; c_write = out_vld & c_full_n (combinational from c_full_n).
- err_mismatch  out  1  sticky: eot seen on some but not all heads.
- elem_count  out  32  data tokens emitted this run, saturates at 2^32-1.

Behaviour:
- Reset (ap_rst=1 at edge):
  - State goes to IDLE; out_vld=0; err_mismatch=0; elem_count=0; mode_r=0.
  - All outputs low except ap_idle=1; c_din=0, c_din_eot=0.
  - Reset mid-run aborts immediately, with no eot emitted and no done pulse.
- FSM states: IDLE, RUN, FLUSH, CLOSE, DONE.
  - IDLE: ap_idle=1. When ap_start=1, latch mode, clear err_mismatch and elem_count, go to RUN next cycle.
  - RUN:
    - fire = all empty_n & no head eot & slot_free, where slot_free = !out_vld | c_write.
    - On fire: in_s_read = all ones; the result is loaded into the output register (c_din, c_din_eot=0, out_vld=1); elem_count increments.
    - All heads valid & all eot & slot_free: pop all, load eot token (c_din=0, c_din_eot=1), go to CLOSE.
    - All heads valid & some (not all) eot: set err_mismatch, go to FLUSH without popping.
    - Otherwise hold: no reads, registers unchanged.
  - FLUSH:
    - Each cycle, pop every valid non-eot head and discard it (no output).
    - Heads already showing eot are held.
    - When all heads are valid and eot and slot_free, pop all, load the eot token, go to CLOSE.
  - CLOSE: wait until the eot token transfers (c_write=1), then go to DONE.
  - DONE: ap_done=ap_ready=1 for exactly one cycle, then go to IDLE. ap_start still high restarts on the following cycle.
- Latency and throughput:
  - Pop at edge t makes c_write possible in cycle t+1.
  - Sustained throughput is 1 token/cycle when all inputs are valid and c_full_n=1.
  - With c_full_n=0 the output register holds its value and c_din is stable; inputs stall with no pops.
- Arithmetic:
  - Add: sum of NCH operands modulo 2^W.
  - Max/min: a reduction tree over NCH operands, signed or unsigned per SIGNED_CMP.
  - Ties: value-identical, so no ordering rule is needed.
- Boundaries:
  - A zero-length run (all first heads eot) emits only the eot token; elem_count=0.
  - ap_start deasserted mid-run has no effect.
  - Same-cycle output drain and load is allowed; slot_free covers this case.
  - elem_count saturates and does not wrap.

Test Plan:
- NCH=3, add; ch0={0..4}, ch1={1..5}, ch2={10..14}, then eot on all, c_full_n=1 -> c_din = 11,14,17,20,23, then eot with c_din_eot=1. ap_done pulses once, elem_count=5, err_mismatch=0, and back-to-back c_write occurs every cycle.
- Same data with c_full_n toggled 1,0,0,1 repeating -> identical output sequence, no drops or duplicates, c_din stable while stalled, no in_s_read while the output register is full and blocked.
- Max signed: heads {-3,7,2}, {5,-8,5} -> 7, 5; min unsigned with heads {0xFFFFFFFF,1,2} -> 1.
- Mismatch: ch1 eot after 2 tokens, ch0/ch2 after 4 -> outputs for 2 tokens, the remaining ch0/ch2 tokens discarded, single eot token, err_mismatch=1, elem_count=2, ap_done pulses.
- Zero-length run plus overflow: all heads eot first -> only the eot token, elem_count=0. Add with 0xFFFFFFFF+1+1 -> 0x00000001.
- ap_rst asserted for 1 cycle mid-RUN (after 2 outputs) -> next cycle ap_idle=1, out_vld=0, c_write=0, no ap_done. A fresh ap_start runs correctly.
